// File: rtl/lib_pow2_seq_if.sv
// Handshake bundle for lib_pow2_seq: vector input side and one-hot output side.
// The design drives the slave side; the producer/consumer drives the master side.
interface lib_pow2_seq_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_vect;
    logic [WIDTH-1:0] in_mask;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_onehot;
    logic [IW-1:0]    out_idx;
    logic             out_last;
    logic             zero_o;

    modport slave (
        input  in_vld, in_vect, in_mask, out_rdy,
        output in_rdy, out_vld, out_onehot, out_idx, out_last, zero_o
    );

    modport master (
        output in_vld, in_vect, in_mask, out_rdy,
        input  in_rdy, out_vld, out_onehot, out_idx, out_last, zero_o
    );
endinterface

// File: rtl/lib_pow2_seq.sv
// Decomposes an accepted vector (minus its bypass mask) into a sequence of one-hot
// words, one per consumer handshake, lowest- or highest-bit first.
module lib_pow2_seq #(
    parameter int LSB_MSB = 0,
    parameter int WIDTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    lib_pow2_seq_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] rem_r, rem_nx_s;
    logic [WIDTH-1:0] onehot_r, onehot_nx_s;
    logic [IW-1:0]    idx_r, idx_nx_s;
    logic             last_r, last_nx_s;
    logic             zero_r, zero_nx_s;
    logic             out_vld_s, in_rdy_s, accept_s, hs_s;
    logic [WIDTH-1:0] load_s;

    function automatic logic [WIDTH-1:0] pick_first(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        int               j;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            j = (LSB_MSB != 0) ? (WIDTH - 1 - i) : i;
            if (v[j] && !found) begin
                r[j]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] onehot_idx(input logic [WIDTH-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r = r | (v[i] ? IW'(i) : {IW{1'b0}});
        end
        return r;
    endfunction

    function automatic logic is_single(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Outputs are forced quiet during reset so nothing can be handshaken in that cycle.
    assign out_vld_s = (state_r == ST_ISSUE) && !rst;
    assign in_rdy_s  = !rst && ((state_r == ST_IDLE) || (out_vld_s && bus.out_rdy && last_r));
    assign accept_s  = bus.in_vld && in_rdy_s;
    assign hs_s      = out_vld_s && bus.out_rdy;
    assign load_s    = bus.in_vect & ~bus.in_mask;

    // Next-state and next-word computation; the word registers track the next remainder.
    always_comb begin
        state_nx_s = state_r;
        rem_nx_s   = rem_r;
        zero_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    rem_nx_s   = load_s;
                    state_nx_s = (load_s != '0) ? ST_ISSUE : ST_IDLE;
                    zero_nx_s  = (load_s == '0);
                end else begin
                    rem_nx_s = rem_r;
                end
            end
            ST_ISSUE: begin
                if (hs_s && !last_r) begin
                    rem_nx_s = rem_r ^ onehot_r;
                end else if (hs_s && accept_s) begin
                    rem_nx_s   = load_s;
                    state_nx_s = (load_s != '0) ? ST_ISSUE : ST_IDLE;
                    zero_nx_s  = (load_s == '0);
                end else if (hs_s) begin
                    rem_nx_s   = '0;
                    state_nx_s = ST_IDLE;
                end else begin
                    rem_nx_s = rem_r;
                end
            end
            default: begin
                rem_nx_s   = '0;
                state_nx_s = ST_IDLE;
            end
        endcase
        if (state_nx_s == ST_ISSUE) begin
            onehot_nx_s = pick_first(rem_nx_s);
            last_nx_s   = is_single(rem_nx_s);
        end else begin
            onehot_nx_s = '0;
            last_nx_s   = 1'b0;
        end
        idx_nx_s = onehot_idx(onehot_nx_s);
    end

    // State, remainder and registered output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rem_r    <= '0;
            onehot_r <= '0;
            idx_r    <= '0;
            last_r   <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            rem_r    <= rem_nx_s;
            onehot_r <= onehot_nx_s;
            idx_r    <= idx_nx_s;
            last_r   <= last_nx_s;
            zero_r   <= zero_nx_s;
        end
    end

    assign bus.out_vld    = out_vld_s;
    assign bus.in_rdy     = in_rdy_s;
    assign bus.out_onehot = rst ? '0 : onehot_r;
    assign bus.out_idx    = rst ? '0 : idx_r;
    assign bus.out_last   = rst ? 1'b0 : last_r;
    assign bus.zero_o     = rst ? 1'b0 : zero_r;
endmodule

// File: tb/tb_lib_pow2_seq.sv
// Directed bench for lib_pow2_seq: LSB-first and MSB-first instances share one stimulus.
module tb_lib_pow2_seq;
    logic clk = 1'b0;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    lib_pow2_seq_if #(.WIDTH(8)) if0 ();
    lib_pow2_seq_if #(.WIDTH(8)) if1 ();

    assign if1.in_vld  = if0.in_vld;
    assign if1.in_vect = if0.in_vect;
    assign if1.in_mask = if0.in_mask;
    assign if1.out_rdy = if0.out_rdy;

    lib_pow2_seq #(.LSB_MSB(0), .WIDTH(8)) dut_lsb (.clk(clk), .rst(rst), .bus(if0));
    lib_pow2_seq #(.LSB_MSB(1), .WIDTH(8)) dut_msb (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_lsb [4] = '{8'h02, 8'h04, 8'h20, 8'h80};
    logic [7:0] exp_msb [4] = '{8'h80, 8'h20, 8'h04, 8'h02};
    logic [2:0] idx_lsb [4] = '{3'd1, 3'd2, 3'd5, 3'd7};

    initial begin
        rst         = 1'b1;
        if0.in_vld  = 1'b0;
        if0.in_vect = 8'h00;
        if0.in_mask = 8'h00;
        if0.out_rdy = 1'b1;
        tick();
        tick();
        check("rst_out_vld", 32'(if0.out_vld), 32'd0);
        check("rst_in_rdy", 32'(if0.in_rdy), 32'd0);
        check("rst_onehot", 32'(if0.out_onehot), 32'd0);
        check("rst_zero", 32'(if0.zero_o), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_rdy", 32'(if0.in_rdy), 32'd1);

        // 0xA6, no mask, both orders
        if0.in_vld  = 1'b1;
        if0.in_vect = 8'hA6;
        tick();
        if0.in_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("a6_vld", 32'(if0.out_vld), 32'd1);
            check("a6_lsb_oh", 32'(if0.out_onehot), 32'(exp_lsb[k]));
            check("a6_lsb_idx", 32'(if0.out_idx), 32'(idx_lsb[k]));
            check("a6_lsb_last", 32'(if0.out_last), (k == 3) ? 32'd1 : 32'd0);
            check("a6_in_rdy", 32'(if0.in_rdy), (k == 3) ? 32'd1 : 32'd0);
            check("a6_msb_oh", 32'(if1.out_onehot), 32'(exp_msb[k]));
            check("a6_msb_last", 32'(if1.out_last), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("a6_done_vld", 32'(if0.out_vld), 32'd0);
        check("a6_done_oh", 32'(if0.out_onehot), 32'd0);

        // 0xA6 with mask 0x06; later input changes must not matter
        if0.in_vld  = 1'b1;
        if0.in_mask = 8'h06;
        tick();
        if0.in_vld  = 1'b0;
        if0.in_vect = 8'hFF;
        if0.in_mask = 8'h00;
        check("mask_oh0", 32'(if0.out_onehot), 32'h20);
        check("mask_last0", 32'(if0.out_last), 32'd0);
        tick();
        check("mask_oh1", 32'(if0.out_onehot), 32'h80);
        check("mask_last1", 32'(if0.out_last), 32'd1);
        tick();
        check("mask_done", 32'(if0.out_vld), 32'd0);

        // fully masked vector
        if0.in_vld  = 1'b1;
        if0.in_vect = 8'h0F;
        if0.in_mask = 8'h0F;
        tick();
        if0.in_vld = 1'b0;
        check("zero_pulse", 32'(if0.zero_o), 32'd1);
        check("zero_vld", 32'(if0.out_vld), 32'd0);
        check("zero_in_rdy", 32'(if0.in_rdy), 32'd1);
        tick();
        check("zero_clear", 32'(if0.zero_o), 32'd0);
        check("zero_vld2", 32'(if0.out_vld), 32'd0);

        // stall then back-to-back vector
        if0.in_mask = 8'h00;
        if0.in_vect = 8'h81;
        if0.in_vld  = 1'b1;
        if0.out_rdy = 1'b0;
        tick();
        if0.in_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_oh", 32'(if0.out_onehot), 32'h01);
            check("stall_idx", 32'(if0.out_idx), 32'd0);
            check("stall_in_rdy", 32'(if0.in_rdy), 32'd0);
            tick();
        end
        if0.out_rdy = 1'b1;
        check("stall_release", 32'(if0.out_onehot), 32'h01);
        tick();
        check("b2b_last_oh", 32'(if0.out_onehot), 32'h80);
        if0.in_vld  = 1'b1;
        if0.in_vect = 8'h10;
        #1;
        check("b2b_in_rdy", 32'(if0.in_rdy), 32'd1);
        tick();
        if0.in_vld = 1'b0;
        check("b2b_vld", 32'(if0.out_vld), 32'd1);
        check("b2b_oh", 32'(if0.out_onehot), 32'h10);
        check("b2b_idx", 32'(if0.out_idx), 32'd4);
        check("b2b_last", 32'(if0.out_last), 32'd1);
        tick();
        check("b2b_done", 32'(if0.out_vld), 32'd0);

        // all ones: eight words in order
        if0.in_vect = 8'hFF;
        if0.in_vld  = 1'b1;
        tick();
        if0.in_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("ff_oh", 32'(if0.out_onehot), 32'd1 << k);
            check("ff_last", 32'(if0.out_last), (k == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check("ff_done", 32'(if0.out_vld), 32'd0);

        // reset mid-vector abandons it
        if0.in_vect = 8'hA6;
        if0.in_vld  = 1'b1;
        tick();
        if0.in_vld = 1'b0;
        check("abort_oh0", 32'(if0.out_onehot), 32'h02);
        tick();
        check("abort_oh1", 32'(if0.out_onehot), 32'h04);
        tick();
        rst = 1'b1;
        #1;
        check("abort_rst_vld", 32'(if0.out_vld), 32'd0);
        check("abort_rst_oh", 32'(if0.out_onehot), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_vld", 32'(if0.out_vld), 32'd0);
        check("abort_in_rdy", 32'(if0.in_rdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_quiet", 32'(if0.out_vld), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
